// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file, its clear
// sequencer, and the decode/writeback stages that size against it.
package regfile_pkg;

   // Default geometry shared with decode and writeback.
   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   // Clear sequencer state encoding.
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_mp_clear_seq.sv
// Post-reset clear sequencer: walks every register once writing zero,
// then hands the array over to the writeback port and raises ready.
module rf_clear_seq
   import regfile_pkg::*;
#(
   parameter int NREGS = RF_NREGS
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic                     ready_o,
   output logic                     clr_we_o,
   output logic [$clog2(NREGS)-1:0] clr_addr_o
);

   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   rf_state_e       state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;

   // State and counter registers; reset restarts the clear from entry 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RF_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: step the counter while clearing, leave after the last entry.
   // The counter parks at its wrapped value in RUN and is not used there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == RF_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = RF_RUN;
         end
      end
   end

   assign ready_o    = (state_q == RF_RUN);
   assign clr_we_o   = (state_q == RF_CLEAR);
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass, a one-bit
// per-register pending scoreboard, and a hardware clear after reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   output logic                          ready_o,
   input  logic                          wr_en_i,
   input  logic [$clog2(NREGS)-1:0]      wr_ptr_i,
   input  logic [XLEN-1:0]               wr_data_i,
   input  logic                          claim_en_i,
   input  logic [$clog2(NREGS)-1:0]      claim_ptr_i,
   input  logic [NRD*$clog2(NREGS)-1:0]  rs_ptr_i,
   output logic [NRD*XLEN-1:0]           rs_data_o,
   output logic [NRD-1:0]                rs_busy_o
);

   localparam int AW = $clog2(NREGS);
   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0]  mem_q [NREGS];
   logic [NREGS-1:0] pend_q, pend_d;

   logic             ready;
   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             wr_hit;
   logic             claim_hit;

   rf_clear_seq #(
      .NREGS (NREGS)
   ) u_clr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ready_o    (ready),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   assign ready_o = ready;

   // Writes and claims only count in RUN and never touch a hardwired zero.
   assign wr_hit    = ready & wr_en_i    & ~(HAS_ZERO && (wr_ptr_i    == '0));
   assign claim_hit = ready & claim_en_i & ~(HAS_ZERO && (claim_ptr_i == '0));

   // Array write mux: the sequencer owns the port during CLEAR, writeback in RUN.
   // No reset here on purpose; the sequencer zeroes the contents instead.
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_hit) begin
         mem_q[wr_ptr_i] <= wr_data_i;
      end
   end

   // Scoreboard next-state: writeback releases, claim sets; claim applied last so
   // a same-cycle claim to the same register survives the older writeback.
   always_comb begin
      pend_d = pend_q;
      if (wr_hit) begin
         pend_d[wr_ptr_i] = 1'b0;
      end
      if (claim_hit) begin
         pend_d[claim_ptr_i] = 1'b1;
      end
   end

   // Pending bits drop asynchronously on reset so nothing is busy during CLEAR.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Read ports: array mux plus bypass compare against the live writeback.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ptr;
      logic            fwd;
      logic            is_zero;
      logic [XLEN-1:0] data;

      assign ptr     = rs_ptr_i[k*AW +: AW];
      assign fwd     = wr_hit && (ptr == wr_ptr_i);
      assign is_zero = HAS_ZERO && (ptr == '0);

      // Port data: forced 0 while clearing or on the hardwired zero entry.
      always_comb begin
         data = '0;
         if (ready && !is_zero) begin
            data = fwd ? wr_data_i : mem_q[ptr];
         end
      end

      assign rs_data_o[k*XLEN +: XLEN] = data;
      // A same-cycle writeback releases busy along with the bypassed data.
      assign rs_busy_o[k] = ready & pend_q[ptr] & ~fwd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default geometry instance plus a small
// NREGS=8 / NRD=3 / XLEN=16 / no-zero-register instance.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A: defaults ----------------
   logic        a_rst, a_ready, a_wr_en, a_claim_en;
   logic [4:0]  a_wr_ptr, a_claim_ptr;
   logic [31:0] a_wr_data;
   logic [9:0]  a_rs_ptr;
   logic [63:0] a_rs_data;
   logic [1:0]  a_rs_busy;

   regfile_mp dut_a (
      .clk_i       (clk),
      .rst_i       (a_rst),
      .ready_o     (a_ready),
      .wr_en_i     (a_wr_en),
      .wr_ptr_i    (a_wr_ptr),
      .wr_data_i   (a_wr_data),
      .claim_en_i  (a_claim_en),
      .claim_ptr_i (a_claim_ptr),
      .rs_ptr_i    (a_rs_ptr),
      .rs_data_o   (a_rs_data),
      .rs_busy_o   (a_rs_busy)
   );

   // ---------------- instance B: sweep ----------------
   logic        b_rst, b_ready, b_wr_en, b_claim_en;
   logic [2:0]  b_wr_ptr, b_claim_ptr;
   logic [15:0] b_wr_data;
   logic [8:0]  b_rs_ptr;
   logic [47:0] b_rs_data;
   logic [2:0]  b_rs_busy;

   regfile_mp #(
      .XLEN     (16),
      .NREGS    (8),
      .NRD      (3),
      .ZERO_REG (0)
   ) dut_b (
      .clk_i       (clk),
      .rst_i       (b_rst),
      .ready_o     (b_ready),
      .wr_en_i     (b_wr_en),
      .wr_ptr_i    (b_wr_ptr),
      .wr_data_i   (b_wr_data),
      .claim_en_i  (b_claim_en),
      .claim_ptr_i (b_claim_ptr),
      .rs_ptr_i    (b_rs_ptr),
      .rs_data_o   (b_rs_data),
      .rs_busy_o   (b_rs_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [4:0] p, input logic [31:0] d);
      a_wr_en = 1'b1; a_wr_ptr = p; a_wr_data = d;
      step();
      a_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      a_wr_en = 0; a_wr_ptr = 0; a_wr_data = 0; a_claim_en = 0; a_claim_ptr = 0;
      a_rs_ptr = {5'd2, 5'd1};
      b_wr_en = 0; b_wr_ptr = 0; b_wr_data = 0; b_claim_en = 0; b_claim_ptr = 0;
      b_rs_ptr = '0;
      #1;
      total++;
      if (a_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready got=%b want=0", a_ready);
      end
      total++;
      if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00) begin
         bad++; $display("FAIL reset_outputs got data=%h busy=%b want 0/00", a_rs_data, a_rs_busy);
      end
      step(); step();
      a_rst = 1'b0; b_rst = 1'b0;
      for (int i = 0; i < 32; i++) step();
      total++;
      if (a_ready !== 1'b1) begin
         bad++; $display("FAIL reset_first_clear got=%b want=1", a_ready);
      end
   endtask

   task automatic test_clear();
      // preload nonzero contents
      for (int i = 1; i < 32; i++) a_write(5'(i), 32'h1000 + 32'(i));
      a_rs_ptr = {5'd9, 5'd4};
      #1;
      total++;
      if (a_rs_data !== {32'h1009, 32'h1004}) begin
         bad++; $display("FAIL clear_preload got=%h want=%h", a_rs_data, {32'h1009, 32'h1004});
      end
      a_rst = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b0 || a_rs_data !== 64'd0) begin
         bad++; $display("FAIL clear_rst_async got ready=%b data=%h want 0/0", a_ready, a_rs_data);
      end
      step(); step(); step();
      a_rst = 1'b0;
      a_claim_en = 1'b1; a_claim_ptr = 5'd4;
      for (int e = 1; e <= 32; e++) begin
         step();
         total++;
         if (a_ready !== (e == 32)) begin
            bad++; $display("FAIL clear_ready edge=%0d got=%b want=%b", e, a_ready, (e == 32));
         end
         if (e < 32) begin
            total++;
            if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00) begin
               bad++; $display("FAIL clear_forced edge=%0d data=%h busy=%b want 0/00", e, a_rs_data, a_rs_busy);
            end
         end
      end
      a_claim_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         a_rs_ptr = {5'd4, 5'(i)};
         #1;
         total++;
         if (a_rs_data[31:0] !== 32'd0) begin
            bad++; $display("FAIL clear_zeroed reg=%0d got=%h want=0", i, a_rs_data[31:0]);
         end
      end
      total++;
      if (a_rs_busy[1] !== 1'b0) begin
         bad++; $display("FAIL clear_claim_ignored got=%b want=0", a_rs_busy[1]);
      end
   endtask

   task automatic test_write_bypass();
      a_rs_ptr = {5'd0, 5'd5};
      a_wr_en = 1'b1; a_wr_ptr = 5'd5; a_wr_data = 32'hDEADBEEF;
      #1;
      total++;
      if (a_rs_data[31:0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL bypass got=%h want=deadbeef", a_rs_data[31:0]);
      end
      step();
      a_wr_en = 1'b0; a_wr_data = 32'h0;
      #1;
      total++;
      if (a_rs_data[31:0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL write_array got=%h want=deadbeef", a_rs_data[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      a_rs_ptr = {5'd0, 5'd0};
      a_wr_en = 1'b1; a_wr_ptr = 5'd0; a_wr_data = 32'h1234;
      a_claim_en = 1'b1; a_claim_ptr = 5'd0;
      #1;
      total++;
      if (a_rs_data[31:0] !== 32'd0) begin
         bad++; $display("FAIL zero_bypass got=%h want=0", a_rs_data[31:0]);
      end
      step();
      a_wr_en = 1'b0; a_claim_en = 1'b0;
      #1;
      total++;
      if (a_rs_data[31:0] !== 32'd0 || a_rs_busy[0] !== 1'b0) begin
         bad++; $display("FAIL zero_reg got data=%h busy=%b want 0/0", a_rs_data[31:0], a_rs_busy[0]);
      end
   endtask

   task automatic test_scoreboard();
      a_rs_ptr = {5'd7, 5'd0};
      a_claim_en = 1'b1; a_claim_ptr = 5'd7;
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b0) begin
         bad++; $display("FAIL claim_not_bypassed got=%b want=0", a_rs_busy[1]);
      end
      step();
      a_claim_en = 1'b0;
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b1) begin
         bad++; $display("FAIL claim_busy got=%b want=1", a_rs_busy[1]);
      end
      a_wr_en = 1'b1; a_wr_ptr = 5'd7; a_wr_data = 32'h55;
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b0 || a_rs_data[63:32] !== 32'h55) begin
         bad++; $display("FAIL wb_release got busy=%b data=%h want 0/55", a_rs_busy[1], a_rs_data[63:32]);
      end
      step();
      a_wr_en = 1'b0;
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b0 || a_rs_data[63:32] !== 32'h55) begin
         bad++; $display("FAIL wb_after got busy=%b data=%h want 0/55", a_rs_busy[1], a_rs_data[63:32]);
      end
      a_claim_en = 1'b1; a_claim_ptr = 5'd7;
      a_wr_en = 1'b1; a_wr_ptr = 5'd7; a_wr_data = 32'h66;
      step();
      a_claim_en = 1'b0; a_wr_en = 1'b0;
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b1 || a_rs_data[63:32] !== 32'h66) begin
         bad++; $display("FAIL claim_wins got busy=%b data=%h want 1/66", a_rs_busy[1], a_rs_data[63:32]);
      end
      a_write(5'd7, 32'h77);
      #1;
      total++;
      if (a_rs_busy[1] !== 1'b0) begin
         bad++; $display("FAIL final_release got=%b want=0", a_rs_busy[1]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      a_write(5'd3, 32'hA5);
      a_claim_en = 1'b1; a_claim_ptr = 5'd3; step();
      a_claim_ptr = 5'd9; step();
      a_claim_en = 1'b0;
      a_rs_ptr = {5'd9, 5'd3};
      #1;
      total++;
      if (a_rs_busy !== 2'b11 || a_rs_data[31:0] !== 32'hA5) begin
         bad++; $display("FAIL mid_setup got busy=%b data=%h want 11/a5", a_rs_busy, a_rs_data[31:0]);
      end
      a_rst = 1'b1;
      #1;
      total++;
      if (a_rs_busy !== 2'b00 || a_ready !== 1'b0) begin
         bad++; $display("FAIL mid_rst got busy=%b ready=%b want 00/0", a_rs_busy, a_ready);
      end
      step(); step();
      a_rst = 1'b0;
      n = 0;
      while (a_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n != 32) begin
         bad++; $display("FAIL mid_clear_len got=%0d want=32", n);
      end
      total++;
      if (a_rs_data[31:0] !== 32'd0 || a_rs_busy !== 2'b00) begin
         bad++; $display("FAIL mid_after got data=%h busy=%b want 0/00", a_rs_data[31:0], a_rs_busy);
      end
   endtask

   task automatic test_sweep();
      int n;
      b_rst = 1'b1;
      step();
      b_rst = 1'b0;
      n = 0;
      while (b_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (n != 8) begin
         bad++; $display("FAIL sweep_clear_len got=%0d want=8", n);
      end
      b_rs_ptr = {3'd2, 3'd1, 3'd0};
      b_wr_en = 1'b1; b_wr_ptr = 3'd0; b_wr_data = 16'hBEEF;
      b_claim_en = 1'b1; b_claim_ptr = 3'd0;
      #1;
      total++;
      if (b_rs_data[15:0] !== 16'hBEEF) begin
         bad++; $display("FAIL sweep_bypass0 got=%h want=beef", b_rs_data[15:0]);
      end
      step();
      b_claim_en = 1'b0;
      b_wr_ptr = 3'd1; b_wr_data = 16'h1111; step();
      b_wr_ptr = 3'd2; b_wr_data = 16'h2222; step();
      b_wr_en = 1'b0;
      #1;
      total++;
      if (b_rs_data !== {16'h2222, 16'h1111, 16'hBEEF}) begin
         bad++; $display("FAIL sweep_ports got=%h want=%h", b_rs_data, {16'h2222, 16'h1111, 16'hBEEF});
      end
      total++;
      if (b_rs_busy !== 3'b001) begin
         bad++; $display("FAIL sweep_busy got=%b want=001", b_rs_busy);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_write_bypass();
      test_zero_reg();
      test_scoreboard();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a built-in pending-write scoreboard and hardware clear sequencer; successor to the single-issue integer register file. It sits between decode (read and claim) and writeback (write) in the core pipeline. It adds write-to-read bypass, per-register busy tracking, and a post-reset clear, replacing simulation-only initialisation.

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of registers; power of two, at least 2. AW = $clog2(NREGS).
- NRD, 2: number of combinational read ports.
- ZERO_REG, 1: when 1, entry 0 reads as 0, ignores writes and is never pending.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ready_o  out  1  high once the clear sequence has completed.
- wr_en_i  in  1  writeback strobe.
- wr_ptr_i  in  AW  writeback destination.
- wr_data_i  in  XLEN  writeback data.
- claim_en_i  in  1  decode marks a destination as pending.
- claim_ptr_i  in  AW  destination being claimed.
- rs_ptr_i  in  NRD*AW  packed read pointers; port k is bits [k*AW +: AW].
- rs_data_o  out  NRD*XLEN  packed read data.
- rs_busy_o  out  NRD  per-port flag: the register has an outstanding claim.

## Operation
- The FSM has two states.
  - **CLEAR:** entered asynchronously on rst_i. Clear counter = 0, all pending bits = 0, ready_o = 0.
  - **RUN:** normal operation.
- **CLEAR behaviour:**
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - After the cycle that writes entry NREGS-1, the FSM enters RUN.
  - wr_en_i and claim_en_i are ignored.
  - rs_data_o and rs_busy_o are forced to 0.
- **Write (RUN):** when wr_en_i is high and the target is not hardwired zero, entry[wr_ptr_i] <= wr_data_i on the rising edge.
- **Read:** combinational.
  - If wr_en_i is high, the target is not hardwired zero, and rs_ptr_k == wr_ptr_i, then port k returns wr_data_i (bypass).
  - Otherwise port k returns entry[rs_ptr_k].
  - With ZERO_REG, pointer 0 returns 0.
- **Scoreboard (RUN):**
  - claim_en_i sets pending[claim_ptr_i].
  - wr_en_i clears pending[wr_ptr_i].
  - If both target the same pointer in the same cycle, the set wins: the new claim outlives the older writeback.
  - Claims to entry 0 under ZERO_REG are dropped.
- **Busy flag:** rs_busy_o[k] = pending[rs_ptr_k] & ~(wr_en_i & wr_ptr_i == rs_ptr_k). A writeback in the same cycle releases busy together with the bypassed data.
- **Multiple claims:** an entry holds one pending bit, so a second claim to an already-pending register is idempotent. Pipeline ordering is decode's responsibility.

## Timing
- **Reset values:** ready_o = 0, rs_data_o = 0, rs_busy_o = 0, FSM = CLEAR, counter = 0.
- **Clear length:** ready_o rises on the NREGS-th rising edge after rst_i deasserts, i.e. 32 cycles at the defaults.
- **Reset mid-clear or mid-run:** asynchronously restarts CLEAR at counter 0 and clears all pending bits.
- **Write latency:** a write is visible through the array one edge after wr_en_i, and visible combinationally the same cycle via bypass.
- **Claim latency:** a claim is visible on rs_busy_o starting the cycle after claim_en_i. Claim is not bypassed.
- **Counter width:** AW bits. The terminal comparison is against NREGS-1, so no wrap occurs in RUN.
- **Timing path:** the read-port path is a mux plus the bypass compare, which is the critical path. Pointers from decode must be stable before the edge.

## Structure
- A shared package regfile_pkg holds:
  - the state encoding (RF_CLEAR = 1'b0, RF_RUN = 1'b1);
  - default XLEN and NREGS constants shared with decode and writeback.
- One sub-module, rf_clear_seq, contains the FSM, the counter, ready_o and the clear-write enable/address. The array write mux selects between the sequencer and the writeback port.
- Read ports are a generate loop over NRD inside regfile_mp.

## Test plan
- **Clear:** assert rst_i for 3 cycles with the array preloaded with nonzero values, then release. Required: ready_o = 0 for 31 edges and 1 after the 32nd; every register reads 0; claims issued during CLEAR leave rs_busy_o = 0.
- **Write and bypass:** wr_en_i = 1, wr_ptr_i = 5, wr_data_i = 0xDEADBEEF, rs_ptr port0 = 5. Required: port0 = 0xDEADBEEF in the same cycle, and still 0xDEADBEEF after wr_en_i drops.
- **Zero register:** write 0x1234 to ptr 0 and claim ptr 0. Required: port reads 0, busy = 0.
- **Scoreboard:**
  - Claim 7, then read port1 = 7 next cycle. Required: busy = 1.
  - Writeback 7 = 0x55. Required: same cycle busy = 0 and data = 0x55.
  - Claim and writeback 7 in the same cycle. Required: busy = 1 the next cycle.
- **Reset mid-operation:**
  - Assert rst_i with regs 3 and 9 pending and reg 3 = 0xA5. Required: all busy = 0 and ready_o = 0 immediately.
  - After release: reg 3 reads 0 after the NREGS-cycle clear.
- **Parameter sweep:** NREGS = 8, NRD = 3, XLEN = 16, ZERO_REG = 0. Required: clear takes 8 cycles; ptr 0 is writable (0xBEEF) and claimable; all 3 ports read independent values.
